// File: rtl/ex_stage.sv
// Execute stage: operand select with one-back bypass, one-hot ALU, branch/jump
// resolution with a wrong-path squash counter, EX/MEM result registers.
// Define EX_PERF_CNT_EN to add the taken_count / squash_count outputs.
module ex_stage #(
  parameter int FLUSH_DEPTH = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            alu_rs2_reg_in,
  input  logic            add_en_in,
  input  logic            sub_en_in,
  input  logic            xor_en_in,
  input  logic            or_en_in,
  input  logic            and_en_in,
  input  logic            eq_en_in,
  input  logic            writeback_en_in,
  input  logic            writeback_from_mem_in,
  input  logic            skip_instr_in,
  input  logic            rs1_take_prev1_in,
  input  logic            rs2_take_prev1_in,
  input  logic            jump_on_alu_true_in,
  input  logic            jump_always_in,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            squash,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_addr_out,
  output logic            writeback_en_out,
  output logic            writeback_from_mem_out,
  output logic            valid_out
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]     taken_count,
  output logic [31:0]     squash_count
`endif
);

  localparam logic [1:0]      FLUSH_LOAD = 2'(FLUSH_DEPTH);
  localparam logic [XLEN-1:0] LINK_OFS   = XLEN'(4);

  logic [1:0]      flush_cnt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] exe_res;
  logic            live;
  logic            taken;

  // Bypass taps our own registered result, so the previous instruction's
  // value is available without waiting for writeback.
  assign op_a    = rs1_take_prev1_in ? result_out : rs1_in;
  assign rs2_fwd = rs2_take_prev1_in ? result_out : rs2_in;
  assign op_b    = alu_rs2_reg_in ? rs2_fwd : imm_in;

  always_comb begin
    // NOTE: default assignment first so no path through the if-chain infers a latch.
    alu_res = '0;
    if (add_en_in)      alu_res = op_a + op_b;
    else if (sub_en_in) alu_res = op_a - op_b;
    else if (xor_en_in) alu_res = op_a ^ op_b;
    else if (or_en_in)  alu_res = op_a | op_b;
    else if (and_en_in) alu_res = op_a & op_b;
    else if (eq_en_in)  alu_res = {{(XLEN-1){1'b0}}, (op_a == op_b)};
  end

  assign live    = !skip_instr_in && (flush_cnt == 2'd0);
  assign taken   = live && (jump_always_in || (jump_on_alu_true_in && alu_res[0]));
  assign exe_res = jump_always_in ? (pc_in + LINK_OFS) : alu_res;

  // A stalled branch is not redirected yet; it is re-evaluated once stall drops.
  assign redirect_valid = taken && !stall;
  assign redirect_pc    = pc_in + imm_in;
  assign squash         = (flush_cnt != 2'd0);

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_out             <= '0;
      store_data_out         <= '0;
      rd_addr_out            <= '0;
      writeback_en_out       <= 1'b0;
      writeback_from_mem_out <= 1'b0;
      valid_out              <= 1'b0;
      flush_cnt              <= 2'd0;
    end else if (!stall) begin
      // Bubbles keep the old result so the bypass still sees the last real value.
      if (!skip_instr_in) result_out <= exe_res;
      store_data_out         <= rs2_fwd;
      rd_addr_out            <= rd_addr_in;
      writeback_en_out       <= writeback_en_in && live;
      writeback_from_mem_out <= writeback_from_mem_in;
      valid_out              <= live;
      if (redirect_valid)          flush_cnt <= FLUSH_LOAD;
      else if (flush_cnt != 2'd0)  flush_cnt <= flush_cnt - 2'd1;
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      taken_count  <= '0;
      squash_count <= '0;
    end else begin
      if (redirect_valid) taken_count <= taken_count + 32'd1;
      if (!stall && squash && !skip_instr_in) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipelined RISC-V core; sits directly downstream of the ID/EX register and consumes its outputs.
- Selects operands, including a one-back bypass from its own last result, and evaluates the one-hot ALU op.
- Resolves branches and jumps, drives the PC redirect, and squashes wrong-path instructions with a counter.
- Registers results into the EX/MEM boundary.

Parameters:
- FLUSH_DEPTH, 2, number of younger instructions squashed after a taken branch/jump (1..3).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- stall  in  1  hold all registered state this cycle
- rd_addr_in  in  5  destination register
- rs1_in, rs2_in  in  XLEN  register operands
- imm_in  in  XLEN  immediate
- pc_in  in  XLEN  instruction PC
- alu_rs2_reg_in  in  1  1 = operand B is rs2, 0 = operand B is imm
- add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in, eq_en_in  in  1 each  one-hot ALU op
- writeback_en_in, writeback_from_mem_in  in  1 each  writeback controls
- skip_instr_in  in  1  instruction is a bubble
- rs1_take_prev1_in, rs2_take_prev1_in  in  1 each  bypass select
- jump_on_alu_true_in, jump_always_in  in  1 each  branch / jump
- redirect_valid  out  1  combinational: fetch must load redirect_pc
- redirect_pc  out  XLEN  combinational: pc_in + imm_in
- squash  out  1  registered: flush counter nonzero
- result_out  out  XLEN  registered ALU result or link address
- store_data_out  out  XLEN  registered forwarded rs2
- rd_addr_out  out  5  registered
- writeback_en_out, writeback_from_mem_out  out  1 each  registered
- valid_out  out  1  registered: instruction is live

Behaviour:
- Operand A = rs1_take_prev1_in ? result_out : rs1_in.
- Forwarded rs2 = rs2_take_prev1_in ? result_out : rs2_in.
- Operand B = alu_rs2_reg_in ? forwarded rs2 : imm_in.
- ALU, all XLEN-bit, wrap-around:
  - add = A+B; sub = A-B; xor/or/and bitwise.
  - eq = {XLEN-1 zeros, (A==B)}.
  - No op bit set -> 0. Multiple bits set -> lowest-listed op (add) wins.
- live = !skip_instr_in && (flush_cnt == 0).
- Branch/jump:
  - taken = live && (jump_always_in || (jump_on_alu_true_in && alu[0])).
  - redirect_valid = taken && !stall.
  - Jump result = pc_in + 4, overriding the ALU.
- Flush counter, 2 bits:
  - On redirect_valid, load FLUSH_DEPTH.
  - Otherwise, if nonzero and !stall, decrement.
  - squash = (flush_cnt != 0).
  - Squashed instructions still advance the pipeline but produce valid_out=0, writeback_en_out=0, and no redirect.
- Latency: EX/MEM registers update on the posedge after inputs are presented (1 cycle). Redirect is same-cycle combinational.
- stall=1:
  - All registers hold, including flush_cnt.
  - redirect_valid forced 0; the branch is re-evaluated when stall drops.
- Bubble (skip_instr_in=1):
  - valid_out=0, writeback_en_out=0.
  - result_out holds its previous value so the bypass stays coherent.
- Reset (rst=0 at posedge, any state, mid-flush included):
  - result_out=0, store_data_out=0, rd_addr_out=0.
  - writeback_en_out=0, writeback_from_mem_out=0, valid_out=0.
  - flush_cnt=0, squash=0.
- Reset has priority over stall.

Optional Feature:
- EX_PERF_CNT_EN defined:
  - Adds outputs taken_count (32) and squash_count (32).
  - taken_count increments on each redirect_valid.
  - squash_count increments on each cycle where !stall and squash=1 and skip_instr_in=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, squash=0; first instruction after release executes normally.
- ALU/bypass:
  - add rs1=5, imm=7, alu_rs2_reg=0 -> result_out=12.
  - Next cycle: sub with rs1_take_prev1=1, rs2=2, alu_rs2_reg=1 -> result_out=10.
  - Wrap case: 0xFFFFFFFF+1 -> 0.
- Branch taken:
  - eq, rs1=rs2=3, jump_on_alu_true=1, pc=0x100, imm=0x20 -> redirect_valid=1 same cycle, redirect_pc=0x120.
  - Next 2 instructions -> valid_out=0, writeback_en_out=0; 3rd instruction -> valid_out=1.
- Jump: jump_always=1, pc=0x40, rd=1 -> result_out=0x44, writeback_en_out=1, redirect asserted.
- Stall during flush:
  - Taken branch, then stall=1 for 3 cycles -> squash stays 1, outputs frozen.
  - After release -> 2 further squashed slots.
- Mid-flush reset: taken branch, then rst=0 next cycle -> squash=0; following instruction is live.
